// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// Build option RESP_ERR_EN enables out-of-range error responses in data_mem_responder.
package mem_resp_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 12;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory request/response bundle; the cpu is the master, the responder the slave.
interface data_mem_responder_if
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) ();

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              write_enable;
    logic              read_enable;
    logic [DATA_W-1:0] data_out;
    logic              ready;
    logic              err;

    modport master (
        output address, data_in, write_enable, read_enable,
        input  data_out, ready, err
    );

    modport slave (
        input  address, data_in, write_enable, read_enable,
        output data_out, ready, err
    );

endinterface

// File: rtl/resp_storage.sv
// Single-port word array: synchronous write, registered read (old data on a same-cycle write).
module resp_storage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data-memory responder: latches one request, waits WAIT_STATES cycles, then completes it.
// Define RESP_ERR_EN to flag addresses >= DEPTH with err instead of wrapping them.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    op_e                 op_q, op_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;

    logic                req_c;
    logic                oob_c;
    logic                we_c;
    logic [IDX_W-1:0]    idx_c;
    logic [DATA_W-1:0]   rdata_c;

    assign req_c = bus.write_enable | bus.read_enable;

`ifdef RESP_ERR_EN
    assign oob_c = ({1'b0, addr_q} >= (ADDR_W + 1)'(DEPTH));
`else
    logic unused_addr_c;
    assign oob_c         = 1'b0;
    assign unused_addr_c = ^addr_q;
`endif

    // In IDLE the array is addressed from the bus so a zero-wait read has data by RESP.
    always_comb begin
        idx_c = addr_q[IDX_W-1:0];
        if (state_q == IDLE) begin
            idx_c = bus.address[IDX_W-1:0];
        end
    end

    assign we_c = (state_q == RESP) && (op_q == OP_WRITE) && !oob_c;

    resp_storage #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (IDX_W)
    ) u_storage (
        .clk   (clk),
        .we    (we_c),
        .addr  (idx_c),
        .wdata (wdata_q),
        .rdata (rdata_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        op_d       = op_q;
        data_out_d = data_out_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_c) begin
                    addr_d  = bus.address;
                    wdata_d = bus.data_in;
                    op_d    = bus.write_enable ? OP_WRITE : OP_READ;
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                ready_d = 1'b1;
                err_d   = oob_c;
                if (op_q == OP_READ) begin
                    data_out_d = oob_c ? '0 : rdata_c;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_q       <= OP_READ;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            op_q       <= op_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.ready    = ready_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
module tb_data_mem_responder;

    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;

`ifdef RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
    data_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

    data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_STATES(2)) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a.slave)
    );

    data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic we, input logic re,
                         input logic [AW-1:0] addr, input logic [DW-1:0] d);
        if (sel) begin
            bus_b.write_enable = we;
            bus_b.read_enable  = re;
            bus_b.address      = addr;
            bus_b.data_in      = d;
        end else begin
            bus_a.write_enable = we;
            bus_a.read_enable  = re;
            bus_a.address      = addr;
            bus_a.data_in      = d;
        end
    endtask

    function automatic logic rdy(input bit sel);
        return sel ? bus_b.ready : bus_a.ready;
    endfunction

    function automatic logic [DW-1:0] dout(input bit sel);
        return sel ? bus_b.data_out : bus_a.data_out;
    endfunction

    function automatic logic errf(input bit sel);
        return sel ? bus_b.err : bus_a.err;
    endfunction

    // Issue one access, scramble the inputs after acceptance, and measure edges to ready.
    task automatic access(input bit sel, input logic we, input logic re,
                          input logic [AW-1:0] addr, input logic [DW-1:0] d,
                          input int exp_lat, input string tag,
                          output logic [DW-1:0] q, output logic e);
        int lat;
        drive(sel, we, re, addr, d);
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, ~addr, ~d);
        lat = 0;
        while (!rdy(sel) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        q = dout(sel);
        e = errf(sel);
    endtask

    initial begin
        logic [DW-1:0] q;
        logic          e;
        logic [DW-1:0] exp_d;
        int            nready;

        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_data_out", bus_a.data_out, 32'h0);
        check("rst_a_ready", 32'(bus_a.ready), 32'h0);
        check("rst_a_err", 32'(bus_a.err), 32'h0);
        check("rst_b_data_out", bus_b.data_out, 32'h0);
        check("rst_b_ready", 32'(bus_b.ready), 32'h0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk); #1;

        // Two wait states: write then read back.
        access(1'b0, 1'b1, 1'b0, 12'h010, 32'hDEADBEEF, 3, "a_wr010", q, e);
        check("a_wr010_err", 32'(e), 32'h0);
        check("a_wr010_dout_held", q, 32'h0);
        access(1'b0, 1'b0, 1'b1, 12'h010, 32'h0, 3, "a_rd010", q, e);
        check("a_rd010_data", q, 32'hDEADBEEF);
        check("a_rd010_err", 32'(e), 32'h0);
        @(posedge clk); #1;
        check("a_ready_pulse_low", 32'(bus_a.ready), 32'h0);

        // Both enables: a write that leaves data_out untouched.
        access(1'b0, 1'b1, 1'b1, 12'h020, 32'h12345678, 3, "a_both020", q, e);
        check("a_both020_dout_held", q, 32'hDEADBEEF);
        access(1'b0, 1'b0, 1'b1, 12'h020, 32'h0, 3, "a_rd020", q, e);
        check("a_rd020_data", q, 32'h12345678);

        // Reset during WAIT aborts the write.
        access(1'b0, 1'b1, 1'b0, 12'h030, 32'h0BADF00D, 3, "a_wr030", q, e);
        access(1'b0, 1'b0, 1'b1, 12'h030, 32'h0, 3, "a_rd030_old", q, e);
        check("a_rd030_old_data", q, 32'h0BADF00D);
        drive(1'b0, 1'b1, 1'b0, 12'h030, 32'hA5A5A5A5);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
        @(posedge clk); #2;
        rst_a = 1'b1;
        #1;
        check("a_midrst_data_out", bus_a.data_out, 32'h0);
        check("a_midrst_ready", 32'(bus_a.ready), 32'h0);
        check("a_midrst_err", 32'(bus_a.err), 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_a = 1'b0;
        @(posedge clk); #1;
        access(1'b0, 1'b0, 1'b1, 12'h030, 32'h0, 3, "a_rd030_after", q, e);
        check("a_rd030_after_data", q, 32'h0BADF00D);

        // Address DEPTH: error response when enabled, wrap to word 0 otherwise.
        access(1'b0, 1'b1, 1'b0, 12'h000, 32'h22222222, 3, "a_wr000", q, e);
        access(1'b0, 1'b1, 1'b0, 12'h400, 32'h11111111, 3, "a_wr400", q, e);
        check("a_wr400_err", 32'(e), 32'(ERR_EN));
        access(1'b0, 1'b0, 1'b1, 12'h400, 32'h0, 3, "a_rd400", q, e);
        check("a_rd400_err", 32'(e), 32'(ERR_EN));
        exp_d = ERR_EN ? 32'h0 : 32'h11111111;
        check("a_rd400_data", q, exp_d);
        @(posedge clk); #1;
        check("a_err_pulse_low", 32'(bus_a.err), 32'h0);
        access(1'b0, 1'b0, 1'b1, 12'h000, 32'h0, 3, "a_rd000", q, e);
        exp_d = ERR_EN ? 32'h22222222 : 32'h11111111;
        check("a_rd000_data", q, exp_d);
        check("a_rd000_err", 32'(e), 32'h0);

        // Zero wait states: write, read, hold, overwrite.
        access(1'b1, 1'b1, 1'b0, 12'h3FF, 32'hCAFEF00D, 1, "b_wr3ff", q, e);
        access(1'b1, 1'b0, 1'b1, 12'h3FF, 32'h0, 1, "b_rd3ff", q, e);
        check("b_rd3ff_data", q, 32'hCAFEF00D);
        repeat (3) @(posedge clk);
        #1;
        check("b_hold_data", bus_b.data_out, 32'hCAFEF00D);
        check("b_hold_ready", 32'(bus_b.ready), 32'h0);
        access(1'b1, 1'b1, 1'b0, 12'h3FF, 32'h55AA55AA, 1, "b_wr3ff_2", q, e);
        check("b_wr3ff_2_dout_held", q, 32'hCAFEF00D);
        access(1'b1, 1'b0, 1'b1, 12'h3FF, 32'h0, 1, "b_rd3ff_2", q, e);
        check("b_rd3ff_2_data", q, 32'h55AA55AA);

        // A held request completes every second cycle.
        drive(1'b1, 1'b0, 1'b1, 12'h3FF, 32'h0);
        nready = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus_b.ready) nready++;
        end
        drive(1'b1, 1'b0, 1'b0, 12'h0, 32'h0);
        check("b_backtoback_count", 32'(nready), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the CPU data-memory interface: accepts read/write requests driven by the cpu (address, data_in, write_enable, read_enable) and answers with data_out plus a one-cycle ready pulse.
- Replaces the zero-wait ram so the core can be exercised against real memory latency.
- Holds its own word-addressed storage and inserts a parameterised number of wait states per access.

Parameters:
- ADDR_W, 12, request address width in words.
- DATA_W, 32, data word width.
- DEPTH, 1024, number of storage words; power of two, at most 2**ADDR_W.
- WAIT_STATES, 2, extra cycles between request acceptance and response; range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  word address of request.
- data_in  in  DATA_W  write data.
- write_enable  in  1  write request, level.
- read_enable  in  1  read request, level.
- data_out  out  DATA_W  read data, valid from the ready cycle and held until the next read completes.
- ready  out  1  one-cycle pulse marking completion of the accepted access.
- err  out  1  one-cycle pulse with ready on an out-of-range access; tied 0 unless RESP_ERR_EN.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: data_out=0, ready=0, err=0, state=IDLE, wait counter=0. Storage contents are not reset.
- States:
  - IDLE: samples requests. If write_enable or read_enable is high at a clock edge, latch address, data_in and op, then go to WAIT (WAIT_STATES>0) or RESP (WAIT_STATES=0).
  - WAIT: count down WAIT_STATES cycles, then go to RESP.
  - RESP: perform the op, drive ready=1 for exactly this cycle, go to IDLE.
- Latency: ready is asserted WAIT_STATES+1 cycles after the accepting edge.
- Write: storage[addr] updated at the RESP edge.
- Read: data_out loads storage[addr] so it is visible in the ready cycle; otherwise data_out holds.
- Both enables high: treat as write; read ignored.
- Inputs are ignored outside IDLE. The latched values are used, so the initiator may change inputs after acceptance.
- A request still asserted in the IDLE cycle after ready is a new access. Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- Read after write to the same address returns the new data.
- Reset mid-WAIT or mid-RESP: abort, no storage update, outputs return to reset values.
- Address indexing without RESP_ERR_EN: index = address mod DEPTH (low log2(DEPTH) bits).

Optional Feature:
- Macro: RESP_ERR_EN.
- Defined: address >= DEPTH is out of range.
  - Write is suppressed; storage unchanged.
  - Read loads data_out=0.
  - err=1 in the same cycle as ready.
  - Latency is unchanged.
- Undefined: addresses wrap modulo DEPTH; err is constant 0.

Decomposition:
- Package mem_resp_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - default ADDR_W/DATA_W constants
  - wait-counter width constant (4)
- One sub-module: resp_storage, a synchronous single-port word array (clk, we, addr, wdata, rdata) with registered read data. The FSM and counter stay in the parent.

Test Plan:
- WAIT_STATES=2: write 0xDEADBEEF to 0x010, then read 0x010 -> ready 3 cycles after each accepting edge; data_out=0xDEADBEEF in the read's ready cycle.
- WAIT_STATES=0: read an unwritten-then-written 0x3FF -> ready 1 cycle after acceptance; data_out matches the written value and holds after ready until the next read.
- write_enable and read_enable both high at 0x020 with data_in=0x12345678 -> treated as write; a later read of 0x020 returns 0x12345678; data_out unchanged during the combined access.
- Reset asserted during WAIT of a write of 0xA5A5A5A5 to 0x030 -> ready/err/data_out go 0 immediately; a later read of 0x030 returns the old value.
- RESP_ERR_EN defined, DEPTH=1024: write 0x11111111 to 0x400, then read 0x400 -> err=1 with ready both times; data_out=0; storage[0x000] unchanged.
- RESP_ERR_EN undefined, same stimulus -> err=0; a read of 0x000 returns 0x11111111 (wrap).
